// File: rtl/pipe_scoreboard.sv
// In-order hazard/occupancy controller: shadows every in-flight destination register,
// stalls decode on RAW hazards, kills the youngest entries on flush and reports retirement.
module pipe_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int REG_AW      = 5,
    parameter int DEPTH       = 4,
    parameter int FLUSH_DEPTH = 2,
    parameter bit FORWARD     = 1'b0,
    parameter bit RF_BYPASS   = 1'b1,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                advance,
    input  logic                flush,
    input  logic                issue_valid,
    input  logic                issue_we,
    input  logic                issue_is_load,
    input  logic [REG_AW-1:0]   issue_rd,
    input  logic [REG_AW-1:0]   issue_rs1,
    input  logic [REG_AW-1:0]   issue_rs2,
    input  logic                issue_use_rs1,
    input  logic                issue_use_rs2,
    output logic                stall,
    output logic                issue_fire,
    output logic                retire_valid,
    output logic                retire_we,
    output logic [REG_AW-1:0]   retire_rd,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [CW-1:0]       inflight_count,
    output logic                busy
);

    logic [DEPTH-1:0]  e_valid;
    logic [DEPTH-1:0]  e_we;
    logic [REG_AW-1:0] e_rd [DEPTH];
    // Load-use is only ever checked against the youngest entry, so only it keeps the flag.
    logic              e0_load;
    logic [DEPTH-1:0]  kept;
    logic              haz1;
    logic              haz2;
    logic              stall_raw;

    function automatic logic hazard(input logic use_src, input logic [REG_AW-1:0] src);
        logic hit;
        hit = 1'b0;
        if (FORWARD) begin
            hit = e_valid[0] && e_we[0] && e0_load && (e_rd[0] == src);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_valid[i] && e_we[i] && (e_rd[i] == src) &&
                    !((i == DEPTH - 1) && RF_BYPASS && advance))
                    hit = 1'b1;
            end
        end
        return use_src && (src != '0) && hit;
    endfunction

    always_comb begin
        haz1      = hazard(issue_use_rs1, issue_rs1);
        haz2      = hazard(issue_use_rs2, issue_rs2);
        stall_raw = issue_valid && (haz1 || haz2 || !advance || flush);
        // Decode-side outputs are held low while reset is asserted.
        stall      = rst && stall_raw;
        issue_fire = rst && issue_valid && !stall_raw;

        retire_valid = advance && e_valid[DEPTH-1];
        retire_we    = retire_valid && e_we[DEPTH-1];
        retire_rd    = retire_valid ? e_rd[DEPTH-1] : '0;

        pending_mask   = '0;
        inflight_count = '0;
        kept           = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (e_valid[i] && e_we[i])
                pending_mask[e_rd[i]] = 1'b1;
            inflight_count = inflight_count + CW'(e_valid[i]);
            kept[i] = e_valid[i] && !(flush && (i < FLUSH_DEPTH));
        end
        pending_mask[0] = 1'b0;
        busy = (inflight_count != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_valid <= '0;
            e_we    <= '0;
            e0_load <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                e_rd[i] <= '0;
        end else if (advance) begin
            e_valid[0] <= issue_fire;
            e_we[0]    <= issue_we && (issue_rd != '0);
            e0_load    <= issue_is_load;
            e_rd[0]    <= issue_rd;
            for (int i = 1; i < DEPTH; i++) begin
                e_valid[i] <= kept[i-1];
                e_we[i]    <= e_we[i-1];
                e_rd[i]    <= e_rd[i-1];
            end
        end else begin
            e_valid <= kept;
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: a retire queue filled at issue time is checked at retirement,
// with a non-forwarding and a forwarding instance driven from the same stimulus.
module tb_pipe_scoreboard;

    localparam int AW = 5;
    localparam int NR = 32;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst;
    logic advance, flush, issue_valid, issue_we, issue_is_load;
    logic [AW-1:0] issue_rd, issue_rs1, issue_rs2;
    logic issue_use_rs1, issue_use_rs2;
    logic fwd_mode;

    logic n_stall, n_fire, n_rv, n_rwe, n_busy;
    logic [AW-1:0] n_rrd;
    logic [NR-1:0] n_pm;
    logic [CW-1:0] n_cnt;
    logic f_stall, f_fire, f_rv, f_rwe, f_busy;
    logic [AW-1:0] f_rrd;
    logic [NR-1:0] f_pm;
    logic [CW-1:0] f_cnt;

    logic o_stall, o_fire, o_rv, o_rwe, o_busy;
    logic [AW-1:0] o_rrd;
    logic [NR-1:0] o_pm;
    logic [CW-1:0] o_cnt;

    int checks = 0;
    int errors = 0;
    logic [AW:0] exp_q [$];

    always #5 clk = ~clk;

    pipe_scoreboard #(.FORWARD(1'b0)) dut (
        .clk(clk), .rst(rst), .advance(advance), .flush(flush),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_is_load(issue_is_load),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .stall(n_stall), .issue_fire(n_fire), .retire_valid(n_rv), .retire_we(n_rwe),
        .retire_rd(n_rrd), .pending_mask(n_pm), .inflight_count(n_cnt), .busy(n_busy));

    pipe_scoreboard #(.FORWARD(1'b1)) dut_fwd (
        .clk(clk), .rst(rst), .advance(advance), .flush(flush),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_is_load(issue_is_load),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .stall(f_stall), .issue_fire(f_fire), .retire_valid(f_rv), .retire_we(f_rwe),
        .retire_rd(f_rrd), .pending_mask(f_pm), .inflight_count(f_cnt), .busy(f_busy));

    assign o_stall = fwd_mode ? f_stall : n_stall;
    assign o_fire  = fwd_mode ? f_fire  : n_fire;
    assign o_rv    = fwd_mode ? f_rv    : n_rv;
    assign o_rwe   = fwd_mode ? f_rwe   : n_rwe;
    assign o_rrd   = fwd_mode ? f_rrd   : n_rrd;
    assign o_pm    = fwd_mode ? f_pm    : n_pm;
    assign o_cnt   = fwd_mode ? f_cnt   : n_cnt;
    assign o_busy  = fwd_mode ? f_busy  : n_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_we = 0; issue_is_load = 0;
        issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        issue_use_rs1 = 0; issue_use_rs2 = 0; flush = 0; advance = 1;
    endtask

    task automatic set_issue(input logic [AW-1:0] rd, input logic we, input logic ld,
                             input logic [AW-1:0] rs1, input logic u1,
                             input logic [AW-1:0] rs2, input logic u2);
        issue_valid = 1; issue_rd = rd; issue_we = we; issue_is_load = ld;
        issue_rs1 = rs1; issue_use_rs1 = u1; issue_rs2 = rs2; issue_use_rs2 = u2;
    endtask

    // Called at posedge+3 with inputs set; checks this cycle, then moves to the next posedge+3.
    task automatic step(input string tag, input logic exp_stall, input logic exp_ret);
        logic fire_exp;
        logic [AW:0] ent;
        #1;
        fire_exp = issue_valid && !exp_stall;
        chk({tag, "_stall"}, o_stall, exp_stall);
        chk({tag, "_fire"}, o_fire, fire_exp);
        chk({tag, "_retv"}, o_rv, exp_ret);
        if (exp_ret) begin
            chk({tag, "_q_nonempty"}, exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                ent = exp_q.pop_front();
                chk({tag, "_ret_we"}, o_rwe, ent[AW]);
                chk({tag, "_ret_rd"}, o_rrd, ent[AW-1:0]);
            end
        end
        if (fire_exp)
            exp_q.push_back({issue_we && (issue_rd != '0), issue_rd});
        @(posedge clk);
        #3;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, o_stall, 0);
        chk({tag, "_fire"}, o_fire, 0);
        chk({tag, "_retv"}, o_rv, 0);
        chk({tag, "_rwe"}, o_rwe, 0);
        chk({tag, "_rrd"}, o_rrd, 0);
        chk({tag, "_pm"}, o_pm, 0);
        chk({tag, "_cnt"}, o_cnt, 0);
        chk({tag, "_busy"}, o_busy, 0);
    endtask

    initial begin
        fwd_mode = 0;
        rst = 0;
        idle_inputs();
        issue_valid = 1;
        @(posedge clk);
        #3;
        chk_all_zero("reset");
        rst = 1;
        idle_inputs();

        // RAW without bypass: x5 producer holds consumer until it is retiring.
        set_issue(5'd5, 1, 0, 5'd0, 0, 5'd0, 0);
        step("raw_t0", 0, 0);
        chk("raw_pm", o_pm, 32'h20);
        chk("raw_cnt", o_cnt, 1);
        set_issue(5'd8, 1, 0, 5'd5, 1, 5'd0, 0);
        step("raw_t1", 1, 0);
        step("raw_t2", 1, 0);
        step("raw_t3", 1, 0);
        step("raw_t4", 0, 1);
        idle_inputs();
        step("raw_d5", 0, 0);
        step("raw_d6", 0, 0);
        step("raw_d7", 0, 0);
        step("raw_d8", 0, 1);
        chk("raw_busy", o_busy, 0);

        // x0 destination and sources.
        set_issue(5'd0, 1, 0, 5'd0, 0, 5'd0, 0);
        step("x0_t0", 0, 0);
        chk("x0_pm", o_pm, 0);
        chk("x0_cnt", o_cnt, 1);
        set_issue(5'd9, 1, 0, 5'd0, 1, 5'd0, 1);
        step("x0_t1", 0, 0);
        idle_inputs();
        step("x0_d2", 0, 0);
        step("x0_d3", 0, 0);
        step("x0_d4", 0, 1);
        step("x0_d5", 0, 1);

        // Flush kills B and C, A survives.
        set_issue(5'd1, 1, 0, 5'd0, 0, 5'd0, 0);
        step("fl_a", 0, 0);
        set_issue(5'd2, 1, 0, 5'd0, 0, 5'd0, 0);
        step("fl_b", 0, 0);
        set_issue(5'd3, 1, 0, 5'd0, 0, 5'd0, 0);
        step("fl_c", 0, 0);
        chk("fl_pm_pre", o_pm, 32'he);
        set_issue(5'd10, 1, 0, 5'd0, 0, 5'd0, 0);
        flush = 1;
        step("fl_kill", 1, 0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        idle_inputs();
        chk("fl_pm_post", o_pm, 32'h2);
        chk("fl_cnt", o_cnt, 1);
        step("fl_ret_a", 0, 1);
        chk("fl_busy", o_busy, 0);

        // Hold with two x4 writers, oldest sitting in the retire slot.
        set_issue(5'd4, 1, 0, 5'd0, 0, 5'd0, 0);
        step("hd_w1", 0, 0);
        step("hd_w2", 0, 0);
        idle_inputs();
        step("hd_i2", 0, 0);
        step("hd_i3", 0, 0);
        chk("hd_cnt", o_cnt, 2);
        chk("hd_pm", o_pm, 32'h10);
        set_issue(5'd11, 1, 0, 5'd0, 0, 5'd0, 0);
        advance = 0;
        step("hd_h0", 1, 0);
        step("hd_h1", 1, 0);
        step("hd_h2", 1, 0);
        chk("hd_cnt_frozen", o_cnt, 2);
        idle_inputs();
        step("hd_r1", 0, 1);
        chk("hd_pm_mid", o_pm, 32'h10);
        step("hd_r2", 0, 1);
        chk("hd_pm_end", o_pm, 0);
        chk("hd_busy", o_busy, 0);

        // Asynchronous reset with a full pipe.
        for (int i = 0; i < 4; i++) begin
            set_issue(AW'(12 + i), 1, 0, 5'd0, 0, 5'd0, 0);
            step("ar_fill", 0, 0);
        end
        chk("ar_cnt_full", o_cnt, 4);
        #2;
        rst = 0;
        #1;
        chk_all_zero("ar_mid");
        exp_q.delete();
        @(posedge clk);
        #3;
        chk_all_zero("ar_hold");
        rst = 1;
        idle_inputs();
        for (int i = 0; i < 4; i++)
            step("ar_post", 0, 0);

        // Forwarding instance: load-use stalls once, ALU producer never.
        fwd_mode = 1;
        set_issue(5'd7, 1, 1, 5'd0, 0, 5'd0, 0);
        step("fw_lw", 0, 0);
        set_issue(5'd13, 1, 0, 5'd0, 0, 5'd7, 1);
        step("fw_use1", 1, 0);
        step("fw_use2", 0, 0);
        set_issue(5'd20, 1, 0, 5'd0, 0, 5'd0, 0);
        step("fw_add", 0, 0);
        set_issue(5'd21, 1, 0, 5'd20, 1, 5'd0, 0);
        step("fw_cons", 0, 1);
        idle_inputs();
        step("fw_d5", 0, 0);
        step("fw_d6", 0, 1);
        step("fw_d7", 0, 1);
        step("fw_d8", 0, 1);
        chk("fw_busy", o_busy, 0);
        chk("q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
